// File: rtl/hamming_secded_decode_stream.sv
`default_nettype none
// ============================================================================
// Module      : hamming_secded_decode_stream
// Description : Two-stage pipelined extended-Hamming SEC-DED decoder with
//               valid/ready streaming and saturating error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_secded_decode_stream #(
    parameter int DATA_W = 4,
    parameter int PAR_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W+PAR_W:0]      data_i,
    input  logic                       corr_en_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       single_err_o,
    output logic                       double_err_o,
    output logic [PAR_W-1:0]           err_pos_o,
    input  logic                       cnt_clr_i,
    output logic [CNT_W-1:0]           corr_cnt_o,
    output logic [CNT_W-1:0]           uncorr_cnt_o
);

    localparam int CODE_W = DATA_W + PAR_W + 1;
    localparam int N      = DATA_W + PAR_W;
    localparam logic [PAR_W-1:0] C_N = PAR_W'(N);

    // XOR of the indices of every set bit in Hamming positions 1..N.
    function automatic logic [PAR_W-1:0] calc_syndrome(input logic [CODE_W-1:0] cw);
        logic [PAR_W-1:0]  s;
        logic [CODE_W-1:0] t;
        s = '0;
        for (int i = 1; i <= N; i++) begin
            t = cw >> i;
            if (t[0]) s = s ^ PAR_W'(i);
        end
        return s;
    endfunction

    // Data bits occupy the non-power-of-two positions, lowest first; shift in from the top.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] cw);
        logic [DATA_W-1:0] d;
        logic [CODE_W-1:0] t;
        d = '0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                t = cw >> i;
                d = (d >> 1) | (DATA_W'(t[0]) << (DATA_W - 1));
            end
        end
        return d;
    endfunction

    logic                r_s1_valid;
    logic [CODE_W-1:0]   r_s1_cw;
    logic                r_s1_corr;
    logic [PAR_W-1:0]    r_s1_s;
    logic                r_s1_p;

    logic                r_s2_valid;
    logic [DATA_W-1:0]   r_s2_data;
    logic                r_s2_single;
    logic                r_s2_double;
    logic [PAR_W-1:0]    r_s2_pos;

    logic [CNT_W-1:0]    r_corr_cnt;
    logic [CNT_W-1:0]    r_uncorr_cnt;

    logic                w_s2_load;
    logic                w_in_ready;
    logic                w_out_xfer;
    logic [PAR_W-1:0]    w_s1_s;
    logic                w_s1_p;
    logic                w_in_range;
    logic                w_single;
    logic                w_double;
    logic                w_flip;
    logic [CODE_W-1:0]   w_fixed_cw;

    assign w_s2_load  = !r_s2_valid || out_ready_i;
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_out_xfer = r_s2_valid && out_ready_i;

    assign w_s1_s = calc_syndrome(data_i);
    assign w_s1_p = ^data_i;

    assign w_in_range = (r_s1_s != '0) && (r_s1_s <= C_N);
    assign w_single   = r_s1_p && ((r_s1_s == '0) || w_in_range);
    assign w_double   = (r_s1_p && !((r_s1_s == '0) || w_in_range)) ||
                        (!r_s1_p && (r_s1_s != '0));
    assign w_flip     = r_s1_p && w_in_range && r_s1_corr;
    assign w_fixed_cw = r_s1_cw ^ (CODE_W'(w_flip) << r_s1_s);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_corr  <= 1'b0;
            r_s1_s     <= '0;
            r_s1_p     <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid_i;
            if (in_valid_i) begin
                r_s1_cw   <= data_i;
                r_s1_corr <= corr_en_i;
                r_s1_s    <= w_s1_s;
                r_s1_p    <= w_s1_p;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_valid  <= 1'b0;
            r_s2_data   <= '0;
            r_s2_single <= 1'b0;
            r_s2_double <= 1'b0;
            r_s2_pos    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data   <= extract_data(w_fixed_cw);
                r_s2_single <= w_single;
                r_s2_double <= w_double;
                r_s2_pos    <= r_s1_s;
            end
        end
    end

    // Clear beats a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_out_xfer) begin
            if (r_s2_single && !(&r_corr_cnt))
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            if (r_s2_double && !(&r_uncorr_cnt))
                r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
        end
    end

    assign in_ready_o   = w_in_ready;
    assign out_valid_o  = r_s2_valid;
    assign data_o       = r_s2_data;
    assign single_err_o = r_s2_single;
    assign double_err_o = r_s2_double;
    assign err_pos_o    = r_s2_pos;
    assign corr_cnt_o   = r_corr_cnt;
    assign uncorr_cnt_o = r_uncorr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_decode_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_secded_decode_stream
// Description : Directed table-driven bench for the SEC-DED stream decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_decode_stream;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, CNT_W = 16
    logic       rst, in_valid, in_ready, corr_en, out_valid, out_ready, cnt_clr;
    logic [7:0] din;
    logic [3:0] dout;
    logic       single_err, double_err;
    logic [2:0] err_pos;
    logic [15:0] corr_cnt, uncorr_cnt;

    // Saturation instance, CNT_W = 2
    logic       rst2, in_valid2, in_ready2, corr_en2, out_valid2, out_ready2, cnt_clr2;
    logic [7:0] din2;
    logic [3:0] dout2;
    logic       single_err2, double_err2;
    logic [2:0] err_pos2;
    logic [1:0] corr_cnt2, uncorr_cnt2;

    hamming_secded_decode_stream #(.DATA_W(4), .PAR_W(3), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data_i(din), .corr_en_i(corr_en), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .data_o(dout), .single_err_o(single_err), .double_err_o(double_err),
        .err_pos_o(err_pos), .cnt_clr_i(cnt_clr), .corr_cnt_o(corr_cnt),
        .uncorr_cnt_o(uncorr_cnt)
    );

    hamming_secded_decode_stream #(.DATA_W(4), .PAR_W(3), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst2), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .data_i(din2), .corr_en_i(corr_en2), .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .data_o(dout2), .single_err_o(single_err2), .double_err_o(double_err2),
        .err_pos_o(err_pos2), .cnt_clr_i(cnt_clr2), .corr_cnt_o(corr_cnt2),
        .uncorr_cnt_o(uncorr_cnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] cw;
        logic       ce;
        logic [3:0] data;
        logic       single;
        logic       dbl;
        logic [2:0] pos;
    } vec_t;

    vec_t vecs[14];

    logic [7:0] stream_cw[8];
    logic [3:0] stream_dat[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_corr, exp_uncorr;
        int tx, rx, cyc;
        logic       prev_stall;
        logic [3:0] prev_data;
        logic       seen_block;

        //              cw     ce    data  sgl   dbl   pos
        vecs[0]  = '{8'hAA, 1'b1, 4'hB, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{8'h8A, 1'b1, 4'hB, 1'b1, 1'b0, 3'd5};
        vecs[2]  = '{8'h8A, 1'b0, 4'h9, 1'b1, 1'b0, 3'd5};
        vecs[3]  = '{8'hAB, 1'b1, 4'hB, 1'b1, 1'b0, 3'd0};
        vecs[4]  = '{8'hCA, 1'b1, 4'hD, 1'b0, 1'b1, 3'd3};
        vecs[5]  = '{8'h00, 1'b1, 4'h0, 1'b0, 1'b0, 3'd0};
        vecs[6]  = '{8'hFF, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0};
        vecs[7]  = '{8'hF7, 1'b1, 4'hF, 1'b1, 1'b0, 3'd3};
        vecs[8]  = '{8'hF7, 1'b0, 4'hE, 1'b1, 1'b0, 3'd3};
        vecs[9]  = '{8'hAE, 1'b1, 4'hB, 1'b1, 1'b0, 3'd2};
        vecs[10] = '{8'hA9, 1'b1, 4'hB, 1'b0, 1'b1, 3'd1};
        vecs[11] = '{8'h80, 1'b1, 4'h0, 1'b1, 1'b0, 3'd7};
        vecs[12] = '{8'h80, 1'b0, 4'h8, 1'b1, 1'b0, 3'd7};
        vecs[13] = '{8'h33, 1'b0, 4'h2, 1'b0, 1'b0, 3'd0};

        stream_cw  = '{8'h0F, 8'h33, 8'h3C, 8'h55, 8'h5A, 8'h66, 8'h69, 8'h00};
        stream_dat = '{4'h1,  4'h2,  4'h3,  4'h4,  4'h5,  4'h6,  4'h7,  4'h0};

        rst = 1'b1; in_valid = 1'b0; din = '0; corr_en = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
        rst2 = 1'b1; in_valid2 = 1'b0; din2 = '0; corr_en2 = 1'b1; out_ready2 = 1'b1; cnt_clr2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset data_o", 32'(dout), 32'd0);
        chk("reset single", 32'(single_err), 32'd0);
        chk("reset double", 32'(double_err), 32'd0);
        chk("reset err_pos", 32'(err_pos), 32'd0);
        chk("reset corr_cnt", 32'(corr_cnt), 32'd0);
        chk("reset uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // Single-word table: latency, decoded data, flags, counters
        exp_corr = 0; exp_uncorr = 0;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1; din = vecs[i].cw; corr_en = vecs[i].ce;
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d no out after 1 cycle", i), 32'(out_valid), 32'd0);
            @(posedge clk); @(negedge clk);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d data_o", i), 32'(dout), 32'(vecs[i].data));
            chk($sformatf("v%0d single", i), 32'(single_err), 32'(vecs[i].single));
            chk($sformatf("v%0d double", i), 32'(double_err), 32'(vecs[i].dbl));
            chk($sformatf("v%0d err_pos", i), 32'(err_pos), 32'(vecs[i].pos));
            chk($sformatf("v%0d corr_cnt before xfer", i), 32'(corr_cnt), 32'(exp_corr));
            if (vecs[i].single) exp_corr++;
            if (vecs[i].dbl) exp_uncorr++;
            @(posedge clk); @(negedge clk);
            chk($sformatf("v%0d corr_cnt", i), 32'(corr_cnt), 32'(exp_corr));
            chk($sformatf("v%0d uncorr_cnt", i), 32'(uncorr_cnt), 32'(exp_uncorr));
            chk($sformatf("v%0d out_valid drained", i), 32'(out_valid), 32'd0);
        end

        // Back-to-back stream with backpressure: 1010... then three low cycles
        tx = 0; rx = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; seen_block = 1'b0;
        corr_en = 1'b1;
        while (rx < 8 && cyc < 200) begin
            if (cyc < 10)       out_ready = (cyc % 2) == 0;
            else if (cyc < 13)  out_ready = 1'b0;
            else                out_ready = 1'b1;
            in_valid = (tx < 8);
            din = (tx < 8) ? stream_cw[tx] : 8'h00;
            #1;
            if (prev_stall)
                chk($sformatf("stall stable data c%0d", cyc), 32'(dout), 32'(prev_data));
            if (out_valid && out_ready) begin
                chk($sformatf("stream word %0d", rx), 32'(dout), 32'(stream_dat[rx]));
                chk($sformatf("stream flags %0d", rx), 32'({single_err, double_err}), 32'd0);
                rx++;
            end
            if (in_valid && !in_ready) seen_block = 1'b1;
            if (in_valid && in_ready) tx++;
            prev_stall = out_valid && !out_ready;
            prev_data  = dout;
            cyc++;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream all words received", 32'(rx), 32'd8);
        chk("stream in_ready dropped", 32'(seen_block), 32'd1);
        @(negedge clk);
        chk("stream no extra word", 32'(out_valid), 32'd0);
        chk("stream clean words not counted", 32'(corr_cnt), 32'(exp_corr));

        // Saturation at CNT_W=2 with five single-error words
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'b1; din2 = 8'h8A;
            @(posedge clk); @(negedge clk);
        end
        in_valid2 = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("sat corr_cnt", 32'(corr_cnt2), 32'd3);
        chk("sat uncorr_cnt", 32'(uncorr_cnt2), 32'd0);

        // Clear in the same cycle as a counted transfer
        in_valid2 = 1'b1; din2 = 8'h8A;
        @(posedge clk); @(negedge clk);
        in_valid2 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("clr word present", 32'(out_valid2 && single_err2), 32'd1);
        cnt_clr2 = 1'b1;
        @(posedge clk); @(negedge clk);
        cnt_clr2 = 1'b0;
        chk("clr beats increment", 32'(corr_cnt2), 32'd0);
        in_valid2 = 1'b1; din2 = 8'hCA;
        @(posedge clk); @(negedge clk);
        in_valid2 = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("count after clr", 32'(uncorr_cnt2), 32'd1);

        // Reset with two words in flight
        out_ready2 = 1'b0;
        in_valid2 = 1'b1; din2 = 8'h8A;
        @(posedge clk); @(negedge clk);
        din2 = 8'hCA;
        @(posedge clk); @(negedge clk);
        in_valid2 = 1'b0;
        chk("inflight out_valid before rst", 32'(out_valid2), 32'd1);
        chk("inflight pipe full", 32'(in_ready2), 32'd0);
        rst2 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst drops out_valid", 32'(out_valid2), 32'd0);
        rst2 = 1'b0; out_ready2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("rst no word c%0d", i), 32'(out_valid2), 32'd0);
        end
        chk("rst uncorr_cnt", 32'(uncorr_cnt2), 32'd0);
        chk("rst corr_cnt", 32'(corr_cnt2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
